// File: rtl/or_reduce_scheduler.sv
// Time-multiplexed OR reduction: round-robin grant, one CHUNK slice per cycle.
// Define OR_REDUCE_SCHED_EARLY_EXIT_EN to finish as soon as a set slice is seen.
module or_reduce_scheduler #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 64,
  parameter int CHUNK = 16,
  localparam int NCHUNK = WIDTH / CHUNK,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int KW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic [CHUNK-1:0]      red_in,
  input  logic                  red_out,
  output logic                  rsp_valid,
  output logic [IDW-1:0]        rsp_id,
  output logic                  rsp_data,
  input  logic                  rsp_ready,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [KW-1:0]    k_q, k_d;
  logic             acc_q, acc_d;
  logic [IDW-1:0]   last_q, last_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic             rsp_data_q, rsp_data_d;
  logic             rsp_valid_q, rsp_valid_d;

  logic             found;
  logic [IDW-1:0]   gidx;
  logic [IDW-1:0]   cand;

  // Scan farthest-first so the nearest valid index after last_q wins.
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    cand  = '0;
    for (int j = NREQ; j >= 1; j--) begin
      cand = IDW'((32'(last_q) + 32'(j)) % 32'(NREQ));
      if (req_valid[cand]) begin
        found = 1'b1;
        gidx  = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && found && !rst)
      req_ready[gidx] = 1'b1;
  end

  always_comb begin
    red_in = '0;
    if (state_q == RUN)
      red_in = cap_q[32'(k_q)*CHUNK +: CHUNK];
  end

  assign busy      = (state_q != IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;

  always_comb begin
    state_d     = state_q;
    cap_d       = cap_q;
    k_d         = k_q;
    acc_d       = acc_q;
    last_d      = last_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = rsp_valid_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d  = RUN;
          cap_d    = req_data[32'(gidx)*WIDTH +: WIDTH];
          last_d   = gidx;
          rsp_id_d = gidx;
          acc_d    = 1'b0;
          k_d      = '0;
        end
      end
      RUN: begin
        acc_d = acc_q | red_out;
        k_d   = k_q + KW'(1);
`ifdef OR_REDUCE_SCHED_EARLY_EXIT_EN
        if (red_out) begin
          state_d     = RESP;
          rsp_data_d  = 1'b1;
          rsp_valid_d = 1'b1;
        end else
`endif
        if (32'(k_q) == NCHUNK - 1) begin
          state_d     = RESP;
          rsp_data_d  = acc_q | red_out;
          rsp_valid_d = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cap_q       <= '0;
      k_q         <= '0;
      acc_q       <= 1'b0;
      last_q      <= IDW'(NREQ - 1);
      rsp_id_q    <= '0;
      rsp_data_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cap_q       <= cap_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      last_q      <= last_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

endmodule

// File: tb/tb_or_reduce_scheduler.sv
// Randomised and directed bench for or_reduce_scheduler against a
// transaction-timeline model.
module tb_or_reduce_scheduler;

  localparam int NREQ = 4;
  localparam int WIDTH = 64;
  localparam int CHUNK = 16;
  localparam int NCHUNK = 4;

  logic clk = 1'b0;
  logic rst;
  logic [NREQ-1:0] req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0] req_ready;
  logic [CHUNK-1:0] red_in;
  logic red_out;
  logic rsp_valid;
  logic [1:0] rsp_id;
  logic rsp_data;
  logic rsp_ready;
  logic busy;

  logic [1:0] v2;
  logic [31:0] d2;
  logic [1:0] rdy2;
  logic [15:0] ri2;
  logic ro2;
  logic rv2;
  logic [0:0] id2;
  logic rd2;
  logic rr2;
  logic busy2;

  assign red_out = |red_in;
  assign ro2 = |ri2;

  always #5 clk = ~clk;

  or_reduce_scheduler #(.NREQ(4), .WIDTH(64), .CHUNK(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .red_in(red_in), .red_out(red_out),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_ready(rsp_ready), .busy(busy)
  );

  or_reduce_scheduler #(.NREQ(2), .WIDTH(16), .CHUNK(16)) dut2 (
    .clk(clk), .rst(rst), .req_valid(v2), .req_data(d2),
    .req_ready(rdy2), .red_in(ri2), .red_out(ro2),
    .rsp_valid(rv2), .rsp_id(id2), .rsp_data(rd2),
    .rsp_ready(rr2), .busy(busy2)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] v, input int last);
    for (int j = 1; j <= NREQ; j++)
      if (v[(last + j) % NREQ]) return (last + j) % NREQ;
    return -1;
  endfunction

  // Cycle after accept on which the response becomes visible.
  function automatic int resp_age(input logic [WIDTH-1:0] v);
`ifdef OR_REDUCE_SCHED_EARLY_EXIT_EN
    for (int k = 0; k < NCHUNK; k++)
      if (|v[k*CHUNK +: CHUNK]) return k + 2;
`endif
    return NCHUNK + 1;
  endfunction

  int cyc = 0;
  bit inflight = 0;
  int acc_cyc, m_id, m_ra;
  int m_last = NREQ - 1;
  logic [WIDTH-1:0] m_vec;
  bit prev_rv = 0;
  int g_q[$], gc_q[$], lat_q[$], hs_q[$];

  always @(negedge clk) begin
    int age, p;
    logic [NREQ-1:0] e_rdy;
    logic [CHUNK-1:0] e_red;
    logic e_busy, e_rv;
    cyc++;
    if (rst) begin
      chk("rst_busy", busy, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_red_in", red_in, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_data", rsp_data, 0);
      inflight = 0;
      m_last = NREQ - 1;
      prev_rv = 0;
    end else begin
      age = cyc - acc_cyc;
      p = -1;
      e_rdy = '0;
      e_red = '0;
      e_busy = 1'b0;
      e_rv = 1'b0;
      if (!inflight) begin
        p = pick(req_valid, m_last);
        if (p >= 0) e_rdy[p] = 1'b1;
      end else if (age < m_ra) begin
        e_busy = 1'b1;
        e_red = m_vec[(age-1)*CHUNK +: CHUNK];
      end else begin
        e_busy = 1'b1;
        e_rv = 1'b1;
      end
      chk("req_ready", req_ready, e_rdy);
      chk("red_in", red_in, e_red);
      chk("busy", busy, e_busy);
      chk("rsp_valid", rsp_valid, e_rv);
      if (e_rv) begin
        chk("rsp_id", rsp_id, m_id);
        chk("rsp_data", rsp_data, |m_vec);
      end
      if (rsp_valid && !prev_rv && inflight) lat_q.push_back(age);
      prev_rv = rsp_valid;
      if (!inflight && p >= 0) begin
        inflight = 1;
        acc_cyc = cyc;
        m_id = p;
        m_last = p;
        m_vec = req_data[p*WIDTH +: WIDTH];
        m_ra = resp_age(m_vec);
        g_q.push_back(p);
        gc_q.push_back(cyc);
      end else if (inflight && age >= m_ra && rsp_ready) begin
        inflight = 0;
        hs_q.push_back(cyc);
      end
    end
  end

  function automatic logic [63:0] rnd_vec();
    logic [63:0] one = 64'h1;
    case ($urandom_range(3))
      0: return 64'h0;
      1: return one << $urandom_range(63);
      2: return {$urandom, $urandom};
      default: return one << (16 * $urandom_range(3) + $urandom_range(15));
    endcase
  endfunction

  task automatic cyc1();
    @(posedge clk);
    #1;
  endtask

  function automatic int at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -99;
  endfunction

  initial begin
    int gb, lb, hb;
    rst = 1;
    req_valid = '0;
    req_data = '0;
    rsp_ready = 0;
    v2 = '0;
    d2 = '0;
    rr2 = 0;
    repeat (2) cyc1();
    rst = 0;

    // Requester 0, all-zero vector
    req_valid = 4'b0001;
    rsp_ready = 1;
    cyc1();
    req_valid = '0;
    repeat (8) cyc1();
    chk("t1_grant", at(g_q, 0), 0);
    chk("t1_latency", at(lat_q, 0), 5);

    // Requester 2, bit in top chunk
    req_data[2*WIDTH +: WIDTH] = 64'h0001_0000_0000_0000;
    req_valid = 4'b0100;
    cyc1();
    req_valid = '0;
    repeat (8) cyc1();
    chk("t2_grant", at(g_q, 1), 2);
    chk("t2_latency", at(lat_q, 1), 5);

    // Requester 1, bit in chunk 0
    req_data[1*WIDTH +: WIDTH] = 64'h1;
    req_valid = 4'b0010;
    cyc1();
    req_valid = '0;
    repeat (8) cyc1();
    chk("t3_grant", at(g_q, 2), 1);
`ifdef OR_REDUCE_SCHED_EARLY_EXIT_EN
    chk("t3_latency", at(lat_q, 2), 2);
`else
    chk("t3_latency", at(lat_q, 2), 5);
`endif

    // All requesters continuously valid after reset
    rst = 1;
    cyc1();
    gb = g_q.size();
    for (int i = 0; i < NREQ; i++) req_data[i*WIDTH +: WIDTH] = rnd_vec();
    rst = 0;
    req_valid = 4'hF;
    repeat (30) cyc1();
    req_valid = '0;
    repeat (8) cyc1();
    for (int i = 0; i < 5; i++)
      chk("rr_order", at(g_q, gb + i), i % NREQ);
    for (int i = 1; i < 5; i++)
      chk("rr_spacing", at(gc_q, gb + i) - at(gc_q, gb + i - 1), 6);

    // Response stall with other requests pending
    gb = g_q.size();
    hb = hs_q.size();
    rsp_ready = 0;
    req_data[3*WIDTH +: WIDTH] = 64'h0000_0040_0000_0000;
    req_valid = 4'b1000;
    cyc1();
    req_valid = 4'b0111;
    repeat (14) cyc1();
    rsp_ready = 1;
    cyc1();
    cyc1();
    req_valid = '0;
    repeat (8) cyc1();
    chk("stall_grant", at(g_q, gb), 3);
    chk("stall_next_id", at(g_q, gb + 1), 0);
    chk("stall_next_cyc", at(gc_q, gb + 1), at(hs_q, hb) + 1);

    // Reset during RUN at chunk 2
    req_data[1*WIDTH +: WIDTH] = 64'h8000_0000_0000_0000;
    req_valid = 4'b0010;
    cyc1();
    req_valid = 4'b0011;
    repeat (2) cyc1();
    gb = g_q.size();
    lb = lat_q.size();
    rst = 1;
    #1;
    chk("async_busy", busy, 0);
    chk("async_red_in", red_in, 0);
    chk("async_rsp_valid", rsp_valid, 0);
    chk("async_req_ready", req_ready, 0);
    cyc1();
    rst = 0;
    cyc1();
    req_valid = '0;
    repeat (8) cyc1();
    chk("post_rst_grant", at(g_q, gb), 0);
    chk("post_rst_no_stale", lat_q.size() - lb, 1);

    // Random traffic
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i]) begin
          if ($urandom_range(9) == 0) req_valid[i] = 1'b0;
        end else if ($urandom_range(2) == 0) begin
          req_valid[i] = 1'b1;
          req_data[i*WIDTH +: WIDTH] = rnd_vec();
        end
      end
      rsp_ready = 1'($urandom_range(1));
      cyc1();
    end
    req_valid = '0;
    rsp_ready = 1;
    repeat (20) cyc1();

    // Single-chunk, two-requester instance
    v2 = 2'b10;
    d2 = {16'h8000, 16'h0000};
    rr2 = 1;
    @(negedge clk);
    chk("n1_req_ready", rdy2, 2'b10);
    cyc1();
    v2 = '0;
    @(negedge clk);
    chk("n1_red_in", ri2, 16'h8000);
    chk("n1_busy", busy2, 1);
    chk("n1_rv_early", rv2, 0);
    @(negedge clk);
    chk("n1_rsp_valid", rv2, 1);
    chk("n1_rsp_data", rd2, 1);
    chk("n1_rsp_id", id2, 1);
    @(negedge clk);
    chk("n1_rv_drop", rv2, 0);
    repeat (2) cyc1();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
